// File: rtl/exe_stage_pipelined.sv
// exe_stage_pipelined
// -------------------
// Registered execute stage. It holds the operand forwarding muxes, the
// single-cycle ALU, a branch-target adder and an iterative shift-add
// multiplier (MUL / MLA). It also owns the EXE/MEM output register.
//
// Handshake: an instruction moves from ID into this stage on a rising edge
// where in_valid & in_ready & !flush. in_ready is high only in IDLE, while
// not stalled and out of reset. It does not depend on in_valid, so ID may
// hold an instruction until it is taken. out_valid marks a result in the
// output register. It stays up for exactly one edge unless stall holds it.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready   instruction handshake with ID
//   stall, flush        downstream hold / kill (flush dominates)
//   exec_cmd            ALU command
//   is_mul, is_mla      multiply and multiply-accumulate select
//   s_bit               update flags
//   pc_in, signed_imm   PC+4 and word branch offset
//   op_a, op_b, op_acc  operands from ID
//   fwd_a_sel/fwd_b_sel forwarding selects (1 = mem_wb_val, 2 = wb_wb_val)
//   mem_wb_val/wb_wb_val forwarded results
//   status_in           current NZCV
//   out_valid, alu_res, status_out, status_we, branch_addr  registered results
//   fsm_state           current FSM state (0 = IDLE, 1 = MUL) for observation
module exe_stage_pipelined #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int IMM_W   = 24,
  parameter int MUL_BPC = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic              flush,
  input  logic [3:0]        exec_cmd,
  input  logic              is_mul,
  input  logic              is_mla,
  input  logic              s_bit,
  input  logic [ADDR_W-1:0] pc_in,
  input  logic [IMM_W-1:0]  signed_imm,
  input  logic [DATA_W-1:0] op_a,
  input  logic [DATA_W-1:0] op_b,
  input  logic [DATA_W-1:0] op_acc,
  input  logic [1:0]        fwd_a_sel,
  input  logic [1:0]        fwd_b_sel,
  input  logic [DATA_W-1:0] mem_wb_val,
  input  logic [DATA_W-1:0] wb_wb_val,
  input  logic [3:0]        status_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] alu_res,
  output logic [3:0]        status_out,
  output logic              status_we,
  output logic [ADDR_W-1:0] branch_addr,
  output logic              fsm_state
);

  localparam int ITER  = DATA_W / MUL_BPC;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int MSB   = DATA_W - 1;

  typedef enum logic {IDLE = 1'b0, MUL = 1'b1} state_t;

  state_t state_q, state_d;
  logic   accept;

  // Operand forwarding (op_acc is never forwarded).
  logic [DATA_W-1:0] a_val, b_val;

  always_comb begin
    case (fwd_a_sel)
      2'd1:    a_val = mem_wb_val;
      2'd2:    a_val = wb_wb_val;
      default: a_val = op_a;
    endcase
    case (fwd_b_sel)
      2'd1:    b_val = mem_wb_val;
      2'd2:    b_val = wb_wb_val;
      default: b_val = op_b;
    endcase
  end

  // ALU. Subtraction is A + ~B + 1, so the adder carry-out is NOT borrow.
  // SBC uses C as the carry-in directly: A + ~B + C == A - B - !C.
  logic [DATA_W-1:0] add_b, alu_val;
  logic              add_cin, arith, known;
  logic [DATA_W:0]   sum;
  logic [3:0]        alu_flags;

  always_comb begin
    add_b   = b_val;
    add_cin = 1'b0;
    arith   = 1'b0;
    known   = 1'b1;
    alu_val = '0;
    case (exec_cmd)
      4'b0001: alu_val = b_val;
      4'b1001: alu_val = ~b_val;
      4'b0010: arith = 1'b1;
      4'b0011: begin
        arith   = 1'b1;
        add_cin = status_in[1];
      end
      4'b0100: begin
        arith   = 1'b1;
        add_b   = ~b_val;
        add_cin = 1'b1;
      end
      4'b0101: begin
        arith   = 1'b1;
        add_b   = ~b_val;
        add_cin = status_in[1];
      end
      4'b0110: alu_val = a_val & b_val;
      4'b0111: alu_val = a_val | b_val;
      4'b1000: alu_val = a_val ^ b_val;
      default: known = 1'b0;
    endcase
    sum = {1'b0, a_val} + {1'b0, add_b} + {{DATA_W{1'b0}}, add_cin};
    if (arith) alu_val = sum[DATA_W-1:0];
    alu_flags = status_in;
    if (known) begin
      alu_flags[3] = alu_val[MSB];
      alu_flags[2] = (alu_val == '0);
    end
    if (arith) begin
      alu_flags[1] = sum[DATA_W];
      alu_flags[0] = (a_val[MSB] == add_b[MSB]) && (alu_val[MSB] != a_val[MSB]);
    end
  end

  // Branch target: sign-extend the word offset, scale by 4, wrap at ADDR_W.
  function automatic logic [ADDR_W-1:0] branch_target(input logic [ADDR_W-1:0] pc,
                                                       input logic [IMM_W-1:0]  imm);
    logic [ADDR_W-1:0] off;
    off = ADDR_W'($signed(imm));
    return pc + (off << 2);
  endfunction

  // Multiplier state. mul_a shifts left and mul_b shifts right, so each
  // step adds the next MUL_BPC bits of B (LSB first) weighted by the shifted A.
  logic [DATA_W-1:0] mul_a, mul_b, mul_p, mul_next;
  logic [CNT_W-1:0]  mul_cnt;
  logic [1:0]        mul_cv;
  logic              mul_s;
  logic [ADDR_W-1:0] mul_pc;
  logic [IMM_W-1:0]  mul_imm;

  always_comb begin
    mul_next = mul_p;
    for (int k = 0; k < MUL_BPC; k++) begin
      if (mul_b[k]) mul_next = mul_next + (mul_a << k);
    end
  end

  assign in_ready  = (state_q == IDLE) && !stall && rst;
  assign accept    = in_valid && in_ready && !flush;
  assign fsm_state = state_q;

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = IDLE;
    end else if (!stall) begin
      case (state_q)
        IDLE:    if (accept && is_mul) state_d = MUL;
        MUL:     if (mul_cnt == '0) state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid   <= 1'b0;
      alu_res     <= '0;
      status_out  <= '0;
      status_we   <= 1'b0;
      branch_addr <= '0;
      mul_a       <= '0;
      mul_b       <= '0;
      mul_p       <= '0;
      mul_cnt     <= '0;
      mul_cv      <= '0;
      mul_s       <= 1'b0;
      mul_pc      <= '0;
      mul_imm     <= '0;
    end else if (flush) begin
      // Datapath registers keep stale values; only the valid bits drop.
      out_valid <= 1'b0;
      status_we <= 1'b0;
    end else if (!stall) begin
      case (state_q)
        IDLE: begin
          out_valid <= 1'b0;
          status_we <= 1'b0;
          if (accept) begin
            if (is_mul) begin
              mul_a   <= a_val;
              mul_b   <= b_val;
              mul_p   <= is_mla ? op_acc : '0;
              mul_cnt <= CNT_W'(ITER - 1);
              mul_cv  <= status_in[1:0];
              mul_s   <= s_bit;
              mul_pc  <= pc_in;
              mul_imm <= signed_imm;
            end else begin
              out_valid   <= 1'b1;
              status_we   <= s_bit;
              alu_res     <= alu_val;
              status_out  <= alu_flags;
              branch_addr <= branch_target(pc_in, signed_imm);
            end
          end
        end
        MUL: begin
          mul_p   <= mul_next;
          mul_a   <= mul_a << MUL_BPC;
          mul_b   <= mul_b >> MUL_BPC;
          mul_cnt <= mul_cnt - CNT_W'(1);
          if (mul_cnt == '0) begin
            out_valid   <= 1'b1;
            status_we   <= mul_s;
            alu_res     <= mul_next;
            status_out  <= {mul_next[MSB], (mul_next == '0), mul_cv};
            branch_addr <= branch_target(mul_pc, mul_imm);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_exe_stage_pipelined.sv
// Self-checking bench for exe_stage_pipelined (default parameters).
module tb_exe_stage_pipelined;

  localparam int DW   = 32;
  localparam int AW   = 32;
  localparam int IW   = 24;
  localparam int ITER = 32;
  localparam int EW   = AW + 4 + 1 + DW;
  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  logic          clk;
  logic          rst;
  logic          in_valid, in_ready, stall, flush;
  logic [3:0]    exec_cmd;
  logic          is_mul, is_mla, s_bit;
  logic [AW-1:0] pc_in;
  logic [IW-1:0] signed_imm;
  logic [DW-1:0] op_a, op_b, op_acc;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic [DW-1:0] mem_wb_val, wb_wb_val;
  logic [3:0]    status_in;
  logic          out_valid;
  logic [DW-1:0] alu_res;
  logic [3:0]    status_out;
  logic          status_we;
  logic [AW-1:0] branch_addr;
  logic          fsm_state;

  int n_checks = 0;
  int n_pass   = 0;
  logic [EW-1:0] exp_q[$];

  exe_stage_pipelined dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .flush(flush), .exec_cmd(exec_cmd), .is_mul(is_mul),
    .is_mla(is_mla), .s_bit(s_bit), .pc_in(pc_in), .signed_imm(signed_imm),
    .op_a(op_a), .op_b(op_b), .op_acc(op_acc), .fwd_a_sel(fwd_a_sel),
    .fwd_b_sel(fwd_b_sel), .mem_wb_val(mem_wb_val), .wb_wb_val(wb_wb_val),
    .status_in(status_in), .out_valid(out_valid), .alu_res(alu_res),
    .status_out(status_out), .status_we(status_we), .branch_addr(branch_addr),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [EW-1:0] got, input logic [EW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic clear_inputs();
    in_valid = 0; stall = 0; flush = 0; exec_cmd = 0; is_mul = 0; is_mla = 0;
    s_bit = 0; pc_in = 0; signed_imm = 0; op_a = 0; op_b = 0; op_acc = 0;
    fwd_a_sel = 0; fwd_b_sel = 0; mem_wb_val = 0; wb_wb_val = 0; status_in = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: plain wide arithmetic on the current input values.
  // Packs {branch, nzcv, we, result}.
  function automatic logic [EW-1:0] model();
    logic [DW-1:0] a, b, res;
    logic [3:0]    f;
    logic          c;
    longint        ua, ub, sa, sb, full, sfull, nc;
    logic [AW-1:0] br;
    case (fwd_a_sel)
      2'd1:    a = mem_wb_val;
      2'd2:    a = wb_wb_val;
      default: a = op_a;
    endcase
    case (fwd_b_sel)
      2'd1:    b = mem_wb_val;
      2'd2:    b = wb_wb_val;
      default: b = op_b;
    endcase
    c  = status_in[1];
    nc = c ? 0 : 1;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    f  = status_in;
    res = '0;
    if (is_mul) begin
      full = ua * ub + (is_mla ? longint'(op_acc) : 0);
      res  = full[31:0];
      f    = {res[31], res == 0, status_in[1:0]};
    end else begin
      case (exec_cmd)
        4'd1: begin res = b;     f[3:2] = {res[31], res == 0}; end
        4'd9: begin res = ~b;    f[3:2] = {res[31], res == 0}; end
        4'd6: begin res = a & b; f[3:2] = {res[31], res == 0}; end
        4'd7: begin res = a | b; f[3:2] = {res[31], res == 0}; end
        4'd8: begin res = a ^ b; f[3:2] = {res[31], res == 0}; end
        4'd2, 4'd3: begin
          full  = ua + ub + ((exec_cmd == 4'd3) ? longint'(c) : 0);
          sfull = sa + sb + ((exec_cmd == 4'd3) ? longint'(c) : 0);
          res   = full[31:0];
          f     = {res[31], res == 0, full[32], (sfull > SMAX) || (sfull < SMIN)};
        end
        4'd4, 4'd5: begin
          full  = ua - ub - ((exec_cmd == 4'd5) ? nc : 0);
          sfull = sa - sb - ((exec_cmd == 4'd5) ? nc : 0);
          res   = full[31:0];
          f     = {res[31], res == 0, ua >= ub + ((exec_cmd == 4'd5) ? nc : 0),
                   (sfull > SMAX) || (sfull < SMIN)};
        end
        default: begin res = '0; f = status_in; end
      endcase
    end
    full = longint'(pc_in) + longint'($signed(signed_imm)) * 4;
    br   = full[31:0];
    return {br, f, s_bit, res};
  endfunction

  // Driver: issue the instruction currently on the inputs, optionally stall
  // for stall_len cycles starting stall_at edges after acceptance, then
  // compare the registered result against the scoreboard.
  task automatic run_op(input int stall_at, input int stall_len);
    logic [EW-1:0] e;
    int lat, busy, exp_lat;
    exp_q.push_back(model());
    exp_lat = is_mul ? ITER + stall_len : 0;
    check("rdy_before_accept", in_ready, 1);
    in_valid = 1;
    tick();
    in_valid = 0;
    // A multiply must use C/V captured at acceptance, not later values.
    status_in = 4'($urandom);
    lat = 0;
    busy = 0;
    while (!out_valid && lat < 300) begin
      if (!in_ready) busy++;
      if (lat == stall_at) stall = 1;
      tick();
      lat++;
      if (lat == stall_at + stall_len) stall = 0;
    end
    stall = 0;
    check("latency", lat, exp_lat);
    check("busy_cycles", busy, exp_lat);
    check("out_valid", out_valid, 1);
    e = exp_q.pop_front();
    check("alu_res", alu_res, e[31:0]);
    check("status_we", status_we, e[32]);
    check("status_out", status_out, e[36:33]);
    check("branch_addr", branch_addr, e[68:37]);
  endtask

  initial begin
    int ov_cnt;
    clear_inputs();
    rst = 0;
    repeat (3) tick();
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_alu_res", alu_res, 0);
    check("rst_status_out", status_out, 0);
    check("rst_status_we", status_we, 0);
    check("rst_branch", branch_addr, 0);
    rst = 1;
    #1;
    check("rel_in_ready", in_ready, 1);
    tick();

    // ADD 7 + 5
    exec_cmd = 4'd2; op_a = 7; op_b = 5; status_in = 0;
    run_op(-1, 0);
    check("add_12", alu_res, 12);
    check("add_nzcv", status_out, 4'b0000);

    // SUB overflow
    clear_inputs();
    exec_cmd = 4'd4; op_a = 32'h8000_0000; op_b = 1; s_bit = 1;
    run_op(-1, 0);
    check("sub_res", alu_res, 32'h7FFF_FFFF);
    check("sub_nzcv", status_out, 4'b0011);
    check("sub_we", status_we, 1);

    // Forwarding
    clear_inputs();
    fwd_a_sel = 1; mem_wb_val = 100; op_a = 0; op_b = 1; exec_cmd = 4'd1;
    run_op(-1, 0);
    check("fwd_mov", alu_res, 1);
    exec_cmd = 4'd2; status_in = 0;
    run_op(-1, 0);
    check("fwd_add", alu_res, 101);
    fwd_b_sel = 2; wb_wb_val = 9; exec_cmd = 4'd1;
    run_op(-1, 0);
    check("fwd_b_mov", alu_res, 9);

    // Stall holds the output register
    stall = 1;
    repeat (3) tick();
    check("stall_valid_hold", out_valid, 1);
    check("stall_res_hold", alu_res, 9);
    check("stall_not_ready", in_ready, 0);
    stall = 0;
    tick();
    check("after_stall_valid", out_valid, 0);

    // Branch targets
    clear_inputs();
    exec_cmd = 4'd1; pc_in = 32'h100; signed_imm = 24'hFFFFFE;
    run_op(-1, 0);
    check("branch_neg", branch_addr, 32'hF8);
    signed_imm = 24'h000004;
    run_op(-1, 0);
    check("branch_pos", branch_addr, 32'h110);

    // MLA wrap-around
    clear_inputs();
    is_mul = 1; is_mla = 1; op_a = 32'hFFFF; op_b = 32'h10001; op_acc = 3;
    status_in = 4'b0011; s_bit = 1;
    run_op(-1, 0);
    check("mla_res", alu_res, 32'h2);
    check("mla_nzcv", status_out, 4'b0011);

    // Multiply with a 5-cycle stall mid-iteration
    clear_inputs();
    is_mul = 1; op_a = 32'd123457; op_b = 32'd98765;
    run_op(10, 5);

    // Flush on cycle 10 of a multiply
    clear_inputs();
    is_mul = 1; op_a = 32'hDEAD; op_b = 32'hBEEF;
    in_valid = 1;
    tick();
    in_valid = 0;
    repeat (9) tick();
    flush = 1;
    tick();
    flush = 0;
    check("flush_valid", out_valid, 0);
    check("flush_ready", in_ready, 1);
    check("flush_state", fsm_state, 0);
    ov_cnt = 0;
    repeat (40) begin
      if (out_valid) ov_cnt++;
      tick();
    end
    check("flush_no_output", ov_cnt, 0);
    clear_inputs();
    exec_cmd = 4'd2; op_a = 3; op_b = 4;
    run_op(-1, 0);

    // Flush dominates acceptance
    is_mul = 1; in_valid = 1; flush = 1;
    tick();
    in_valid = 0; flush = 0;
    check("flush_accept_valid", out_valid, 0);
    check("flush_accept_state", fsm_state, 0);

    // Reset in the middle of a multiply
    clear_inputs();
    is_mul = 1; op_a = 5; op_b = 6;
    in_valid = 1;
    tick();
    in_valid = 0;
    repeat (5) tick();
    rst = 0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_ready", in_ready, 0);
    check("midrst_state", fsm_state, 0);
    check("midrst_res", alu_res, 0);
    #1;
    rst = 1;
    #1;
    check("midrst_rel_ready", in_ready, 1);
    tick();
    check("midrst_after_valid", out_valid, 0);

    // Randomized mix
    for (int i = 0; i < 60; i++) begin
      clear_inputs();
      is_mul     = ($urandom_range(0, 4) == 0);
      is_mla     = is_mul & 1'($urandom_range(0, 1));
      exec_cmd   = 4'($urandom_range(0, 15));
      s_bit      = 1'($urandom_range(0, 1));
      op_a       = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 : $urandom;
      op_b       = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
      op_acc     = $urandom;
      fwd_a_sel  = 2'($urandom_range(0, 3));
      fwd_b_sel  = 2'($urandom_range(0, 3));
      mem_wb_val = $urandom;
      wb_wb_val  = $urandom;
      status_in  = 4'($urandom);
      pc_in      = $urandom;
      signed_imm = 24'($urandom);
      if (is_mul && $urandom_range(0, 1) == 1) run_op($urandom_range(1, 20), $urandom_range(1, 4));
      else run_op(-1, 0);
    end

    check("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
